// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer slice: control bundle, dispatch bundle,
// ROB entry and retire bundle, plus ROB sizing constants and FU port indices.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_PTR_W  = 4;
  localparam int unsigned ROB_PREG_W = 6;
  localparam int unsigned ROB_NCMPL  = 3;

  // Completion port indices
  localparam logic [1:0] FU_ALU0 = 2'b00;
  localparam logic [1:0] FU_ALU1 = 2'b01;
  localparam logic [1:0] FU_MEM  = 2'b10;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       Branch;
    logic       ALUSrc;
    logic [1:0] ALUOp;
  } controlStruct;

  typedef struct packed {
    logic                  valid1;
    logic [ROB_PREG_W-1:0] destReg1;
    logic [ROB_PREG_W-1:0] destRegOld1;
    logic [ROB_PTR_W-1:0]  robNum1;
    controlStruct          control1;
    logic [31:0]           pc1;
    logic                  valid2;
    logic [ROB_PREG_W-1:0] destReg2;
    logic [ROB_PREG_W-1:0] destRegOld2;
    logic [ROB_PTR_W-1:0]  robNum2;
    controlStruct          control2;
    logic [31:0]           pc2;
  } robDispatchStruct;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_PREG_W-1:0] destReg;
    logic [ROB_PREG_W-1:0] destRegOld;
    controlStruct          control;
    logic [31:0]           pc;
  } robEntry;

  typedef struct packed {
    logic [1:0]                 valid;
    logic [1:0][ROB_PREG_W-1:0] destReg;
    logic [1:0][ROB_PREG_W-1:0] destRegOld;
    logic [1:0]                 regwrite;
    logic [1:0]                 memwrite;
    logic [1:0][31:0]           pc;
  } robRetireStruct;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// rob_retire_sel: combinational retire decision for the two oldest entries.
//   entry0/entry1 : ROB entries at head and head+1 (valid/done from status)
//   retire_cnt    : number of entries retiring this cycle (0..2)
//   slot_en       : per-slot retire enable; slot 1 only with slot 0
// Two stores never retire together so the LSQ sees one store commit per cycle.
module rob_retire_sel
  import reorder_buffer_pkg::*;
(
  input  robEntry    entry0,
  input  robEntry    entry1,
  output logic [1:0] retire_cnt,
  output logic [1:0] slot_en
);

  logic ok0, ok1;
  logic unused_fields;

  assign ok0 = entry0.valid & entry0.done;
  assign ok1 = ok0 & entry1.valid & entry1.done
             & ~(entry0.control.MemWrite & entry1.control.MemWrite);

  assign slot_en    = {ok1, ok0};
  assign retire_cnt = {ok1, ok0 & ~ok1};

  assign unused_fields = ^{entry0, entry1};

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: two-wide in-order allocate / out-of-order complete /
// two-wide in-order retire ROB.
//   clk, reset (async, active-low)
//   robDispatch              : two-slot dispatch bundle (robNum2 unused)
//   rob_full                 : fewer than two free entries
//   cmpl_valid/cmpl_robNum   : completion notices, ALU0, ALU1, MEM
//   retire_*                 : registered retire bundle, one cycle per decision
//   rob_count                : occupied entries
//   err_overflow/err_robnum  : sticky dispatch error flags
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned PTR_W    = ROB_PTR_W,
  parameter int unsigned PREG_W   = ROB_PREG_W,
  parameter int unsigned NUM_CMPL = ROB_NCMPL
) (
  input  logic                           clk,
  input  logic                           reset,
  input  robDispatchStruct               robDispatch,
  output logic                           rob_full,
  input  logic [NUM_CMPL-1:0]            cmpl_valid,
  input  logic [NUM_CMPL-1:0][PTR_W-1:0] cmpl_robNum,
  output logic [1:0]                     retire_valid,
  output logic [1:0][PREG_W-1:0]         retire_destReg,
  output logic [1:0][PREG_W-1:0]         retire_destRegOld,
  output logic [1:0]                     retire_regwrite,
  output logic [1:0]                     retire_memwrite,
  output logic [1:0][31:0]               retire_pc,
  output logic [PTR_W:0]                 rob_count,
  output logic                           err_overflow,
  output logic                           err_robnum
);

  robEntry             mem [DEPTH];
  logic [DEPTH-1:0]    valid_q, done_q, valid_d, done_d;
  logic [PTR_W-1:0]    head_q, tail_q, head1, tail1;
  logic [PTR_W:0]      count_q;
  robEntry             e0, e1;
  logic [1:0]          ret_cnt, slot_en;
  logic                disp_ok, disp_two;
  logic [1:0]          disp_cnt;
  robRetireStruct      ret_d, ret_q;
  logic                unused_bits;

  assign head1    = head_q + 1'b1;
  assign tail1    = tail_q + 1'b1;
  assign rob_full = count_q > (PTR_W+1)'(DEPTH-2);
  assign disp_ok  = robDispatch.valid1 & ~rob_full;
  assign disp_two = disp_ok & robDispatch.valid2;
  assign disp_cnt = {disp_two, disp_ok & ~disp_two};

  always_comb begin
    e0       = mem[head_q];
    e0.valid = valid_q[head_q];
    e0.done  = done_q[head_q];
    e1       = mem[head1];
    e1.valid = valid_q[head1];
    e1.done  = done_q[head1];
  end

  rob_retire_sel u_sel (
    .entry0     (e0),
    .entry1     (e1),
    .retire_cnt (ret_cnt),
    .slot_en    (slot_en)
  );

  // Completion is applied first so a notice to a retiring entry is simply
  // overridden by the retire clear; dispatch and retire indices never collide.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int unsigned i = 0; i < NUM_CMPL; i++) begin
      if (cmpl_valid[i] && valid_q[cmpl_robNum[i]]) done_d[cmpl_robNum[i]] = 1'b1;
    end
    if (disp_ok)    begin valid_d[tail_q] = 1'b1; done_d[tail_q] = 1'b0; end
    if (disp_two)   begin valid_d[tail1]  = 1'b1; done_d[tail1]  = 1'b0; end
    if (slot_en[0]) begin valid_d[head_q] = 1'b0; done_d[head_q] = 1'b0; end
    if (slot_en[1]) begin valid_d[head1]  = 1'b0; done_d[head1]  = 1'b0; end
  end

  always_comb begin
    ret_d       = '0;
    ret_d.valid = slot_en;
    if (slot_en[0]) begin
      ret_d.destReg[0]    = e0.destReg;
      ret_d.destRegOld[0] = e0.destRegOld;
      ret_d.regwrite[0]   = e0.control.RegWrite;
      ret_d.memwrite[0]   = e0.control.MemWrite;
      ret_d.pc[0]         = e0.pc;
    end
    if (slot_en[1]) begin
      ret_d.destReg[1]    = e1.destReg;
      ret_d.destRegOld[1] = e1.destRegOld;
      ret_d.regwrite[1]   = e1.control.RegWrite;
      ret_d.memwrite[1]   = e1.control.MemWrite;
      ret_d.pc[1]         = e1.pc;
    end
  end

  // Payload is never reset; valid/done in the status vectors gate it.
  always_ff @(posedge clk) begin
    if (disp_ok) begin
      mem[tail_q] <= '{valid: 1'b1, done: 1'b0, destReg: robDispatch.destReg1,
                       destRegOld: robDispatch.destRegOld1,
                       control: robDispatch.control1, pc: robDispatch.pc1};
    end
    if (disp_two) begin
      mem[tail1] <= '{valid: 1'b1, done: 1'b0, destReg: robDispatch.destReg2,
                      destRegOld: robDispatch.destRegOld2,
                      control: robDispatch.control2, pc: robDispatch.pc2};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ret_q        <= '0;
      err_overflow <= 1'b0;
      err_robnum   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_q + PTR_W'(ret_cnt);
      tail_q  <= tail_q + PTR_W'(disp_cnt);
      count_q <= count_q + (PTR_W+1)'(disp_cnt) - (PTR_W+1)'(ret_cnt);
      ret_q   <= ret_d;
      if (robDispatch.valid1 && rob_full)                err_overflow <= 1'b1;
      if (disp_ok && (robDispatch.robNum1 != tail_q))    err_robnum   <= 1'b1;
    end
  end

  assign retire_valid      = ret_q.valid;
  assign retire_destReg    = ret_q.destReg;
  assign retire_destRegOld = ret_q.destRegOld;
  assign retire_regwrite   = ret_q.regwrite;
  assign retire_memwrite   = ret_q.memwrite;
  assign retire_pc         = ret_q.pc;
  assign rob_count         = count_q;

  assign unused_bits = ^{robDispatch.robNum2};

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  robDispatchStruct      disp;
  logic                  rob_full;
  logic [2:0]            cmpl_valid;
  logic [2:0][3:0]       cmpl_robNum;
  logic [1:0]            retire_valid;
  logic [1:0][5:0]       retire_destReg, retire_destRegOld;
  logic [1:0]            retire_regwrite, retire_memwrite;
  logic [1:0][31:0]      retire_pc;
  logic [4:0]            rob_count;
  logic                  err_overflow, err_robnum;

  reorder_buffer #(.DEPTH(16), .PTR_W(4), .PREG_W(6), .NUM_CMPL(3)) dut (
    .clk(clk), .reset(reset), .robDispatch(disp), .rob_full(rob_full),
    .cmpl_valid(cmpl_valid), .cmpl_robNum(cmpl_robNum),
    .retire_valid(retire_valid), .retire_destReg(retire_destReg),
    .retire_destRegOld(retire_destRegOld), .retire_regwrite(retire_regwrite),
    .retire_memwrite(retire_memwrite), .retire_pc(retire_pc),
    .rob_count(rob_count), .err_overflow(err_overflow), .err_robnum(err_robnum)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    logic [31:0] pc;
    logic [5:0]  rd, rdo;
    logic        rw, mw;
    int          idx;
    bit          done;
  } m_ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0, pc1;
    logic [5:0]  rd0, rd1, rdo0, rdo1;
    logic [1:0]  rw, mw;
  } exp_t;

  m_ent_t      rob_q[$];
  exp_t        exp_q[$];
  int          m_tail = 0;
  bit          m_ovf = 0, m_rnerr = 0;
  logic [31:0] next_pc = '0;
  int          errors = 0, checks = 0;
  bit          mon_en = 0, have_prev = 0;
  logic [31:0] prev_pc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_step();
    int n;
    bit full;
    exp_t e;
    m_ent_t t;
    if (!reset) return;
    n = 0;
    full = rob_q.size() > DEPTH - 2;
    if (rob_q.size() > 0 && rob_q[0].done) n = 1;
    if (n == 1 && rob_q.size() > 1 && rob_q[1].done && !(rob_q[0].mw && rob_q[1].mw)) n = 2;
    if (n > 0) begin
      e = '{v: 2'b01, pc0: rob_q[0].pc, pc1: '0, rd0: rob_q[0].rd, rd1: '0,
            rdo0: rob_q[0].rdo, rdo1: '0, rw: {1'b0, rob_q[0].rw}, mw: {1'b0, rob_q[0].mw}};
      if (n == 2) begin
        e.v = 2'b11; e.pc1 = rob_q[1].pc; e.rd1 = rob_q[1].rd; e.rdo1 = rob_q[1].rdo;
        e.rw[1] = rob_q[1].rw; e.mw[1] = rob_q[1].mw;
      end
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      if (cmpl_valid[i]) begin
        for (int k = 0; k < rob_q.size(); k++) begin
          if (rob_q[k].idx == int'(cmpl_robNum[i])) begin
            t = rob_q[k]; t.done = 1; rob_q[k] = t;
          end
        end
      end
    end
    repeat (n) void'(rob_q.pop_front());
    if (disp.valid1) begin
      if (full) m_ovf = 1;
      else begin
        if (int'(disp.robNum1) != m_tail) m_rnerr = 1;
        rob_q.push_back('{pc: disp.pc1, rd: disp.destReg1, rdo: disp.destRegOld1,
                          rw: disp.control1.RegWrite, mw: disp.control1.MemWrite, idx: m_tail, done: 0});
        m_tail = (m_tail + 1) % DEPTH;
        next_pc = disp.pc1 + 4;
        if (disp.valid2) begin
          rob_q.push_back('{pc: disp.pc2, rd: disp.destReg2, rdo: disp.destRegOld2,
                            rw: disp.control2.RegWrite, mw: disp.control2.MemWrite, idx: m_tail, done: 0});
          m_tail = (m_tail + 1) % DEPTH;
          next_pc = disp.pc2 + 4;
        end
      end
    end
  endtask

  task automatic model_reset();
    rob_q.delete(); exp_q.delete();
    m_tail = 0; m_ovf = 0; m_rnerr = 0; have_prev = 0;
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (reset && mon_en) begin
      chk("rob_count", rob_count, rob_q.size());
      chk("rob_full", rob_full, rob_q.size() > DEPTH - 2);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_robnum", err_robnum, m_rnerr);
      if (retire_valid !== 2'b00) begin
        if (exp_q.size() == 0) chk("unexpected_retire", retire_valid, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("ret_valid", retire_valid, e.v);
          chk("ret_pc0", retire_pc[0], e.pc0);
          chk("ret_pc1", retire_pc[1], e.pc1);
          chk("ret_rd", retire_destReg, {e.rd1, e.rd0});
          chk("ret_rdo", retire_destRegOld, {e.rdo1, e.rdo0});
          chk("ret_regwrite", retire_regwrite, e.rw);
          chk("ret_memwrite", retire_memwrite, e.mw);
          if (have_prev) chk("pc_order", retire_pc[0], prev_pc + 4);
          prev_pc = retire_valid[1] ? retire_pc[1] : retire_pc[0];
          have_prev = 1;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    disp = '0;
    cmpl_valid = '0;
    cmpl_robNum = '0;
  endtask

  task automatic set_disp(input bit v1, input bit v2, input bit mw1, input bit mw2,
                          input logic [3:0] rn, input logic [5:0] rd1, input logic [5:0] rd2);
    disp = '0;
    disp.valid1 = v1; disp.valid2 = v2;
    disp.pc1 = next_pc; disp.pc2 = next_pc + 4;
    disp.destReg1 = rd1; disp.destReg2 = rd2;
    disp.destRegOld1 = 6'($urandom); disp.destRegOld2 = 6'($urandom);
    disp.control1 = controlStruct'($urandom); disp.control2 = controlStruct'($urandom);
    disp.control1.MemWrite = mw1; disp.control2.MemWrite = mw2;
    disp.robNum1 = rn; disp.robNum2 = 4'($urandom);
  endtask

  task automatic drain();
    int p;
    for (int it = 0; it < 100 && rob_q.size() > 0; it++) begin
      clear_inputs();
      p = 0;
      for (int k = 0; k < rob_q.size() && p < 3; k++) begin
        if (!rob_q[k].done) begin
          cmpl_valid[p] = 1'b1; cmpl_robNum[p] = 4'(rob_q[k].idx); p++;
        end
      end
      cycle();
    end
    clear_inputs();
    cycle(); cycle();
    chk("drain_count", rob_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pend[$];
    int sz;
    clear_inputs();
    // Reset
    repeat (3) cycle();
    chk("rst_count", rob_count, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_retire", retire_valid, 0);
    chk("rst_errs", {err_overflow, err_robnum}, 0);
    reset = 1'b1;
    mon_en = 1;

    // Out-of-order completion
    set_disp(1, 1, 0, 0, 4'(m_tail), 6'd33, 6'd34);
    cycle();
    clear_inputs(); cmpl_valid[FU_ALU1] = 1'b1; cmpl_robNum[FU_ALU1] = 4'd1;
    cycle();
    clear_inputs(); cmpl_valid[FU_ALU0] = 1'b1; cmpl_robNum[FU_ALU0] = 4'd0;
    cycle();
    clear_inputs();
    cycle();
    chk("ooo_valid", retire_valid, 2'b11);
    chk("ooo_pc", {retire_pc[1], retire_pc[0]}, {32'h4, 32'h0});
    chk("ooo_rd", retire_destReg, {6'd34, 6'd33});
    cycle();
    chk("ooo_count", rob_count, 0);

    // Fill to capacity, then overflow
    repeat (7) begin set_disp(1, 1, 0, 0, 4'(m_tail), 6'($urandom), 6'($urandom)); cycle(); end
    clear_inputs();
    chk("fill14_count", rob_count, 14);
    chk("fill14_full", rob_full, 0);
    set_disp(1, 1, 0, 0, 4'(m_tail), 6'($urandom), 6'($urandom)); cycle();
    clear_inputs();
    chk("fill16_count", rob_count, 16);
    chk("fill16_full", rob_full, 1);
    chk("fill16_ovf", err_overflow, 0);
    set_disp(1, 1, 0, 0, 4'(m_tail), 6'($urandom), 6'($urandom)); cycle();
    clear_inputs();
    chk("ovf_count", rob_count, 16);
    chk("ovf_flag", err_overflow, 1);
    drain();

    // Store pairing
    set_disp(1, 1, 1, 1, 4'(m_tail), 6'($urandom), 6'($urandom)); cycle();
    clear_inputs();
    cmpl_valid = 3'b101; cmpl_robNum[0] = 4'(rob_q[0].idx); cmpl_robNum[FU_MEM] = 4'(rob_q[1].idx);
    cycle();
    clear_inputs();
    cycle();
    chk("store1_mw", retire_memwrite, 2'b01);
    chk("store1_v", retire_valid, 2'b01);
    cycle();
    chk("store2_mw", retire_memwrite, 2'b01);
    chk("store2_v", retire_valid, 2'b01);
    drain();

    // Wrap-around: 20 pairs, completion one cycle after dispatch
    for (int n = 0; n <= 20; n++) begin
      clear_inputs();
      for (int p = 0; p < 2 && pend.size() > 0; p++) begin
        cmpl_valid[p] = 1'b1; cmpl_robNum[p] = pend.pop_front();
      end
      pend.delete();
      if (n < 20) begin
        set_disp(1, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'(m_tail),
                 6'($urandom), 6'($urandom));
        cmpl_valid[0] = cmpl_valid[0]; // keep completions set above
        pend.push_back(4'(m_tail)); pend.push_back(4'((m_tail + 1) % DEPTH));
      end
      cycle();
    end
    drain();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      clear_inputs();
      if ($urandom_range(0, 3) != 0)
        set_disp(1, $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 4'(m_tail), 6'($urandom), 6'($urandom));
      sz = rob_q.size();
      for (int i = 0; i < 3; i++) begin
        cmpl_valid[i] = 1'($urandom_range(0, 1));
        if (sz > 0 && $urandom_range(0, 3) != 0) cmpl_robNum[i] = 4'(rob_q[$urandom_range(0, sz - 1)].idx);
        else cmpl_robNum[i] = 4'($urandom);
      end
      cycle();
    end
    drain();

    // Wrong robNum1
    chk("robnum_clean", err_robnum, 0);
    set_disp(1, 0, 0, 0, 4'((m_tail + 3) % DEPTH), 6'($urandom), 6'($urandom)); cycle();
    clear_inputs();
    chk("robnum_err", err_robnum, 1);
    drain();

    // Mid-operation reset with 6 entries in flight
    repeat (3) begin
      pend.push_back(4'(m_tail)); pend.push_back(4'((m_tail + 1) % DEPTH));
      set_disp(1, 1, 0, 0, 4'(m_tail), 6'($urandom), 6'($urandom)); cycle();
    end
    clear_inputs();
    chk("pre_rst_count", rob_count, 6);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_count", rob_count, 0);
    chk("async_rst_retire", retire_valid, 0);
    chk("async_rst_errs", {err_overflow, err_robnum}, 0);
    repeat (2) cycle();
    reset = 1'b1;
    while (pend.size() > 0) begin
      clear_inputs();
      for (int p = 0; p < 3 && pend.size() > 0; p++) begin
        cmpl_valid[p] = 1'b1; cmpl_robNum[p] = pend.pop_front();
      end
      cycle();
    end
    clear_inputs();
    repeat (4) begin
      cycle();
      chk("post_rst_no_retire", retire_valid, 0);
    end
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
